// File: rtl/cpu_core_param.sv
// cpu_core_param: parameterised single-issue CPU core; define CPU_CORE_MUL_EN to add the MUL opcode (0x08)
module cpu_core_param #(
    parameter int          DATA_W   = 8,
    parameter int          REG_AW   = 3,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_VALID,
    output logic [31:0]       PC,
    output logic [DATA_W-1:0] RESULT,
    output logic              HALTED,
    output logic              ILLEGAL
);
    typedef enum logic {RUN, HALT} state_t;
    state_t            state_q;
    logic [31:0]       pc_q, pc_d, pc_inc, pc_tgt;
    logic [DATA_W-1:0] result_q, wr_d, rs1, rs2, imm;
    logic [DATA_W-1:0] regs_q [2**REG_AW];
    logic              illegal_q, illegal_d, we_d, halt_d;
    logic [7:0]        op;
    logic [REG_AW-1:0] rd, ra, rb;
    logic              unused_instr;
    assign op           = INSTRUCTION[31:24];
    assign rd           = INSTRUCTION[16 +: REG_AW];
    assign ra           = INSTRUCTION[8 +: REG_AW];
    assign rb           = INSTRUCTION[0 +: REG_AW];
    assign rs1          = regs_q[ra];
    assign rs2          = regs_q[rb];
    assign imm          = DATA_W'(signed'(INSTRUCTION[7:0]));
    assign pc_inc       = pc_q + 32'd4;
    assign pc_tgt       = pc_inc + (32'(signed'(INSTRUCTION[23:16])) << 2);
    assign unused_instr = ^INSTRUCTION;
    assign PC           = pc_q;
    assign RESULT       = result_q;
    assign HALTED       = (state_q == HALT);
    assign ILLEGAL      = illegal_q;
    // decode the current instruction into write data, next PC and flags
    always_comb begin
        we_d      = 1'b0;
        wr_d      = '0;
        pc_d      = pc_inc;
        illegal_d = 1'b0;
        halt_d    = 1'b0;
        case (op)
            8'h00: begin we_d = 1'b1; wr_d = imm; end
            8'h01: begin we_d = 1'b1; wr_d = rs2; end
            8'h02: begin we_d = 1'b1; wr_d = rs1 + rs2; end
            8'h03: begin we_d = 1'b1; wr_d = rs1 - rs2; end
            8'h04: begin we_d = 1'b1; wr_d = rs1 & rs2; end
            8'h05: begin we_d = 1'b1; wr_d = rs1 | rs2; end
            8'h06: pc_d = pc_tgt;
            8'h07: pc_d = (rs1 == rs2) ? pc_tgt : pc_inc;
`ifdef CPU_CORE_MUL_EN
            8'h08: begin we_d = 1'b1; wr_d = rs1 * rs2; end
`endif
            8'hFF: begin pc_d = pc_q; halt_d = 1'b1; end
            default: illegal_d = 1'b1;
        endcase
    end
    // retire one instruction per valid cycle in RUN; HALT is only left by reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            result_q  <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (state_q == RUN && INSTR_VALID) begin
                pc_q      <= pc_d;
                illegal_q <= illegal_d;
                if (halt_d) state_q <= HALT;
                if (we_d) begin
                    regs_q[rd] <= wr_d;
                    result_q   <= wr_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: randomized and directed checks of cpu_core_param against a behavioural model
module tb_cpu_core_param;
    localparam int DW = 8;
    logic          CLK = 1'b0, RESET = 1'b1, INSTR_VALID = 1'b0, HALTED, ILLEGAL;
    logic [31:0]   INSTRUCTION = '0, PC;
    logic [DW-1:0] RESULT;
    int            vecs = 0, errs = 0;
    logic [DW-1:0] m_r [8];
    logic [31:0]   m_pc;
    logic [DW-1:0] m_res;
    logic          m_halt, m_ill;

    cpu_core_param #(.DATA_W(DW), .REG_AW(3), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
        .PC(PC), .RESULT(RESULT), .HALTED(HALTED), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ins(input int op, input int d, input int s1, input int s2);
        return {8'(op), 8'(d), 8'(s1), 8'(s2)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_pc = 32'h0; m_res = '0; m_halt = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_apply(input logic [31:0] i, input logic v);
        int a, b, w, off;
        bit has_w;
        int rd, op;
        m_ill = 1'b0;
        if (m_halt || !v) return;
        op = int'(i[31:24]); rd = int'(i[18:16]);
        a = int'(m_r[i[10:8]]); b = int'(m_r[i[2:0]]);
        off = 4 * int'(signed'(i[23:16]));
        has_w = 1'b1; w = 0;
        if (op == 0) w = int'(signed'(i[7:0]));
        else if (op == 1) w = b;
        else if (op == 2) w = a + b;
        else if (op == 3) w = a - b;
        else if (op == 4) w = a & b;
        else if (op == 5) w = a | b;
`ifdef CPU_CORE_MUL_EN
        else if (op == 8) w = a * b;
`endif
        else has_w = 1'b0;
        if (op == 'hFF) m_halt = 1'b1;
        else if (op == 6 || (op == 7 && a == b)) m_pc = m_pc + 32'(4 + off);
        else m_pc = m_pc + 32'd4;
        if (!has_w && op > 7 && op != 'hFF) m_ill = 1'b1;
        if (has_w) begin
            m_r[rd] = DW'(w);
            m_res   = DW'(w);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic v);
        INSTRUCTION = i; INSTR_VALID = v;
        @(posedge CLK);
        model_apply(i, v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; INSTR_VALID = 1'b0;
        #2;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (PC !== 32'h0 || RESULT !== '0 || HALTED !== 1'b0 || ILLEGAL !== 1'b0) begin
            errs++;
            $display("FAIL reset: pc=%h res=%h halted=%b ill=%b, want pc=0 res=0 halted=0 ill=0", PC, RESULT, HALTED, ILLEGAL);
        end
    endtask

    task automatic test_basic_alu();
        logic [31:0] prog [4];
        logic [7:0]  exp_res [4];
        prog = '{ins(0,1,0,5), ins(0,2,0,3), ins(2,3,1,2), ins(3,4,1,2)};
        exp_res = '{8'd5, 8'd3, 8'd8, 8'd2};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(prog[k], 1'b1);
            vecs++;
            if (RESULT !== exp_res[k] || PC !== 32'(4 * (k + 1))) begin
                errs++;
                $display("FAIL basic_alu[%0d]: res=%h pc=%h, want res=%h pc=%h", k, RESULT, PC, exp_res[k], 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(ins(0,1,0,8'hFF), 1'b1);
        vecs++;
        if (RESULT !== 8'hFF) begin errs++; $display("FAIL wrap_loadi: res=%h, want ff", RESULT); end
        step(ins(2,1,1,1), 1'b1);
        vecs++;
        if (RESULT !== 8'hFE) begin errs++; $display("FAIL wrap_add: res=%h, want fe", RESULT); end
    endtask

    task automatic test_branch();
        do_reset();
        step(ins(0,1,0,5), 1'b1);
        step(ins(0,2,0,3), 1'b1);
        step(ins(7,2,1,1), 1'b1);
        vecs++;
        if (PC !== 32'd20) begin errs++; $display("FAIL beq_taken: pc=%0d, want 20", PC); end
        do_reset();
        step(ins(0,1,0,5), 1'b1);
        step(ins(0,2,0,3), 1'b1);
        step(ins(7,2,1,2), 1'b1);
        vecs++;
        if (PC !== 32'd12) begin errs++; $display("FAIL beq_not_taken: pc=%0d, want 12", PC); end
        step(ins(0,3,0,0), 1'b1);
        step(ins(6,8'hFD,0,0), 1'b1);
        vecs++;
        if (PC !== 32'd8 || RESULT !== 8'd0) begin
            errs++; $display("FAIL jump_back: pc=%0d res=%h, want pc=8 res=0", PC, RESULT);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0;
        logic [DW-1:0] r0;
        do_reset();
        step(ins(0,1,0,7), 1'b1);
        step(ins(8'h42,0,0,0), 1'b1);
        pc0 = PC; r0 = RESULT;
        for (int k = 0; k < 3; k++) begin
            step(ins(0,2,0,8'h11), 1'b0);
            vecs++;
            if (PC !== pc0 || RESULT !== r0 || ILLEGAL !== 1'b0) begin
                errs++; $display("FAIL stall[%0d]: pc=%h res=%h ill=%b, want pc=%h res=%h ill=0", k, PC, RESULT, ILLEGAL, pc0, r0);
            end
        end
        step(ins(0,2,0,8'h11), 1'b1);
        vecs++;
        if (PC !== pc0 + 32'd4 || RESULT !== 8'h11) begin
            errs++; $display("FAIL stall_resume: pc=%h res=%h, want pc=%h res=11", PC, RESULT, pc0 + 32'd4);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        step(ins(0,3,0,8'h2A), 1'b1);
        step(ins(8'h42,3,3,3), 1'b1);
        vecs++;
        if (ILLEGAL !== 1'b1 || PC !== 32'd8 || RESULT !== 8'h2A) begin
            errs++; $display("FAIL illegal_pulse: ill=%b pc=%0d res=%h, want ill=1 pc=8 res=2a", ILLEGAL, PC, RESULT);
        end
        step(ins(1,4,0,3), 1'b1);
        vecs++;
        if (ILLEGAL !== 1'b0 || RESULT !== 8'h2A) begin
            errs++; $display("FAIL illegal_clear: ill=%b res=%h, want ill=0 res=2a", ILLEGAL, RESULT);
        end
        step(ins(0,1,0,7), 1'b1);
        step(ins(0,2,0,9), 1'b1);
        step(ins(8,5,1,2), 1'b1);
        vecs++;
`ifdef CPU_CORE_MUL_EN
        if (RESULT !== 8'd63 || ILLEGAL !== 1'b0) begin
            errs++; $display("FAIL mul: res=%0d ill=%b, want res=63 ill=0", RESULT, ILLEGAL);
        end
`else
        if (RESULT !== 8'd9 || ILLEGAL !== 1'b1) begin
            errs++; $display("FAIL mul_disabled: res=%0d ill=%b, want res=9 ill=1", RESULT, ILLEGAL);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] i;
        int r;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 11);
            i = ins(r <= 8 ? r : (r == 9 ? 8'h42 : (r == 10 ? 8'hA5 : 8'h02)),
                    $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            step(i, $urandom_range(0, 4) != 0);
            vecs++;
            if (PC !== m_pc || RESULT !== m_res || HALTED !== m_halt || ILLEGAL !== m_ill) begin
                errs++;
                $display("FAIL random[%0d] instr=%h: pc=%h res=%h halted=%b ill=%b, want pc=%h res=%h halted=%b ill=%b",
                         k, i, PC, RESULT, HALTED, ILLEGAL, m_pc, m_res, m_halt, m_ill);
            end
        end
    endtask

    task automatic test_halt_and_async_reset();
        do_reset();
        for (int k = 0; k < 6; k++) step(ins(0, k, 0, 10 + k), 1'b1);
        step(ins(8'hFF,0,0,0), 1'b1);
        vecs++;
        if (HALTED !== 1'b1 || PC !== 32'd24) begin
            errs++; $display("FAIL halt_enter: halted=%b pc=%0d, want halted=1 pc=24", HALTED, PC);
        end
        for (int k = 0; k < 4; k++) begin
            step(ins($urandom_range(0, 8), $urandom_range(0, 7), 1, 2), 1'b1);
            vecs++;
            if (HALTED !== 1'b1 || PC !== 32'd24 || RESULT !== 8'd15 || ILLEGAL !== 1'b0) begin
                errs++; $display("FAIL halt_hold[%0d]: halted=%b pc=%0d res=%h ill=%b, want 1 24 0f 0", k, HALTED, PC, RESULT, ILLEGAL);
            end
        end
        #2;
        RESET = 1'b1;
        #1;
        vecs++;
        if (PC !== 32'd0 || HALTED !== 1'b0 || RESULT !== '0 || ILLEGAL !== 1'b0) begin
            errs++; $display("FAIL async_reset: pc=%h halted=%b res=%h ill=%b, want all 0", PC, HALTED, RESULT, ILLEGAL);
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        step(ins(0,7,0,8'h55), 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(ins(1, 7, 0, k), 1'b1);
            vecs++;
            if (RESULT !== 8'h00) begin
                errs++; $display("FAIL reset_regs[r%0d]: res=%h, want 00", k, RESULT);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_alu();
        test_wrap();
        test_branch();
        test_stall();
        test_illegal();
        test_random();
        test_halt_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
